alu_issue_ctrl: RTL

- Initiator side of the ALU operand/function interface, located in the execute stage.
- Accepts operation requests (op select, two operands, tag) from issue logic over a valid/ready handshake.
- Decodes the op select to the 6-bit ALU function code and drives registered operands and function into the ALU.
- Waits a per-op latency, captures the result and flags, and returns them with the tag over a valid/ready response handshake.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_op_decode.sv | 30 +++
 rtl/alu_issue_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU issue controller:
// function codes, op-select values and controller state.
package alu_pkg;

  localparam logic [5:0] ALUFN_ADD  = 6'b000000;
  localparam logic [5:0] ALUFN_SUB  = 6'b000001;
  localparam logic [5:0] ALUFN_MUL  = 6'b000010;
  localparam logic [5:0] ALUFN_AND  = 6'b000100;
  localparam logic [5:0] ALUFN_OR   = 6'b000101;
  localparam logic [5:0] ALUFN_XOR  = 6'b000110;
  localparam logic [5:0] ALUFN_SLL  = 6'b001000;
  localparam logic [5:0] ALUFN_SRL  = 6'b001001;
  localparam logic [5:0] ALUFN_SLT  = 6'b001011;
  // ALU drives a zero result for this code, so it doubles as "no op issued"
  localparam logic [5:0] ALUFN_IDLE = 6'b111111;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_SLT = 4'd8;
  localparam logic [3:0] OP_ILLEGAL_MIN = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Maps the issue-side op select onto the ALU function code and
// flags ops that are illegal or need the multiplier latency.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [3:0] req_op,
  output logic [5:0] alufn,
  output logic       legal,
  output logic       is_mul
);

  always_comb begin
    alufn  = ALUFN_IDLE;
    legal  = (req_op < OP_ILLEGAL_MIN);
    is_mul = (req_op == OP_MUL);
    case (req_op)
      OP_ADD:  alufn = ALUFN_ADD;
      OP_SUB:  alufn = ALUFN_SUB;
      OP_MUL:  alufn = ALUFN_MUL;
      OP_AND:  alufn = ALUFN_AND;
      OP_OR:   alufn = ALUFN_OR;
      OP_XOR:  alufn = ALUFN_XOR;
      OP_SLL:  alufn = ALUFN_SLL;
      OP_SRL:  alufn = ALUFN_SRL;
      OP_SLT:  alufn = ALUFN_SLT;
      default: alufn = ALUFN_IDLE;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage initiator for the ALU: registers operands/function,
// waits the op latency on a down-counter, returns result and flags with the tag.
//
// state   | meaning
// IDLE    | no op in flight, ALU parked on the idle code
// EXEC    | operands driven, counting down the ALU latency
// RESP    | response held on rsp_* until rsp_ready
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [31:0]       req_a,
  input  logic [31:0]       req_b,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [5:0]        alu_fn,
  input  logic [31:0]       alu_otp,
  input  logic              alu_zero,
  input  logic              alu_ovf,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_zero,
  output logic              rsp_ovf,
  output logic              rsp_err,
  output logic [TAG_W-1:0]  rsp_tag
);

  localparam int LAT_MAX = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);
  localparam logic [CNT_W-1:0] ALU_CNT = CNT_W'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic [TAG_W-1:0]  tag_q;
  logic [5:0]        dec_fn;
  logic              dec_legal;
  logic              dec_is_mul;
  logic              accept;

  alu_op_decode u_dec (
    .req_op (req_op),
    .alufn  (dec_fn),
    .legal  (dec_legal),
    .is_mul (dec_is_mul)
  );

  // Ready in RESP follows rsp_ready so a new op can start on the handshake cycle.
  assign req_ready = (state == ST_IDLE) || ((state == ST_RESP) && rsp_ready);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      tag_q     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_fn    <= ALUFN_IDLE;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_ovf   <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_tag   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_RESP: begin
          if (accept) begin
            if (dec_legal) begin
              alu_a     <= req_a;
              alu_b     <= req_b;
              alu_fn    <= dec_fn;
              tag_q     <= req_tag;
              cnt       <= dec_is_mul ? MUL_CNT : ALU_CNT;
              rsp_valid <= 1'b0;
              state     <= ST_EXEC;
            end else begin
              // Illegal ops never reach the ALU; answer immediately with err.
              alu_fn    <= ALUFN_IDLE;
              rsp_valid <= 1'b1;
              rsp_data  <= '0;
              rsp_zero  <= 1'b0;
              rsp_ovf   <= 1'b0;
              rsp_err   <= 1'b1;
              rsp_tag   <= req_tag;
              state     <= ST_RESP;
            end
          end else if ((state == ST_RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
            alu_fn    <= ALUFN_IDLE;
            state     <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          if (cnt == '0) begin
            rsp_valid <= 1'b1;
            rsp_data  <= alu_otp;
            rsp_zero  <= alu_zero;
            rsp_ovf   <= alu_ovf;
            rsp_err   <= 1'b0;
            rsp_tag   <= tag_q;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
